// File: rtl/tcdm_initiator_pkg.sv
// Types shared by the core-side TCDM initiator and the bank-side adapter:
// one AMO encoding, and the request metadata echoed back with every response.
package tcdm_initiator_pkg;

  localparam int unsigned CoreIdWidth  = 8;
  // Tag field in the metadata is fixed-width; the initiator uses the low bits.
  localparam int unsigned MetaTagWidth = 8;

  typedef enum logic [3:0] {
    AmoNone = 4'h0,
    AmoSwap = 4'h1,
    AmoAdd  = 4'h2,
    AmoAnd  = 4'h3,
    AmoOr   = 4'h4,
    AmoXor  = 4'h5,
    AmoMax  = 4'h6,
    AmoMaxu = 4'h7,
    AmoMin  = 4'h8,
    AmoMinu = 4'h9,
    AmoLR   = 4'hA,
    AmoSC   = 4'hB
  } amo_op_t;

  typedef struct packed {
    logic [CoreIdWidth-1:0]  core_id;
    logic [MetaTagWidth-1:0] tag;
  } tcdm_init_meta_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_rob.sv
// Reorder buffer: slots allocated in order at the tail, completed by tag in
// any order, and retired in order from the head.
module tcdm_rob
  import tcdm_initiator_pkg::*;
#(
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned TagWidth       = idx_width(NumOutstanding)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_i,
  input  logic                 alloc_drop_i,
  output logic [TagWidth-1:0]  tail_o,
  output logic                 full_o,
  input  logic                 wr_valid_i,
  input  logic [TagWidth-1:0]  wr_tag_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic                 head_valid_o,
  output logic                 head_drop_o,
  output logic [DataWidth-1:0] head_data_o,
  input  logic                 pop_i
);

  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);

  logic [NumOutstanding-1:0] alloc_q, done_q, drop_q;
  logic [DataWidth-1:0]      data_q [NumOutstanding];
  logic [TagWidth-1:0]       head_q, tail_q;
  logic [CntWidth-1:0]       count_q;

  assign full_o       = (count_q == CntWidth'(NumOutstanding));
  assign tail_o       = tail_q;
  assign head_valid_o = alloc_q[head_q] & done_q[head_q];
  assign head_drop_o  = drop_q[head_q];
  assign head_data_o  = data_q[head_q];

  // Allocation never hits the head slot (not full), a response never hits an
  // unallocated slot, and the popped head is already done: no slot collisions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q <= '0;
      done_q  <= '0;
      drop_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_i) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        drop_q[tail_q]  <= alloc_drop_i;
        tail_q          <= tail_q + TagWidth'(1);
      end
      if (wr_valid_i) begin
        done_q[wr_tag_i] <= 1'b1;
      end
      if (pop_i) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + TagWidth'(1);
      end
      case ({alloc_i, pop_i})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_valid_i) begin
      data_q[wr_tag_i] <= wr_data_i;
    end
  end

  wr_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wr_valid_i |-> (alloc_q[wr_tag_i] && !done_q[wr_tag_i]))
    else $error("tcdm_rob: response for unallocated or completed tag %0d", wr_tag_i);

endmodule

// File: rtl/tcdm_initiator.sv
// Core-side TCDM initiator: tags and forwards core requests, and returns the
// (possibly out-of-order) responses to the core in issue order.
module tcdm_initiator
  import tcdm_initiator_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumOutstanding = 8,
  parameter bit          DropWriteResp  = 1'b1,
  parameter int unsigned TagWidth       = idx_width(NumOutstanding),
  parameter int unsigned BeWidth        = DataWidth / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [CoreIdWidth-1:0] core_id_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [3:0]             req_amo_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [BeWidth-1:0]     req_be_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [AddrWidth-1:0]   out_addr_o,
  output logic [3:0]             out_amo_o,
  output logic                   out_write_o,
  output logic [DataWidth-1:0]   out_wdata_o,
  output logic [BeWidth-1:0]     out_be_o,
  output tcdm_init_meta_t        out_meta_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DataWidth-1:0]   in_rdata_i,
  input  tcdm_init_meta_t        in_meta_i
);

  if (DataWidth != 32) begin : g_bad_data_width
    $error("tcdm_initiator: only DataWidth=32 is supported");
  end
  if ((NumOutstanding < 2) || ((NumOutstanding & (NumOutstanding - 1)) != 0)) begin : g_bad_depth
    $error("tcdm_initiator: NumOutstanding must be a power of two >= 2");
  end
  if (TagWidth >= MetaTagWidth) begin : g_bad_tag
    $error("tcdm_initiator: NumOutstanding too large for the metadata tag field");
  end

  logic                 full, issue, drop, pop;
  logic [TagWidth-1:0]  tail;
  logic                 head_valid, head_drop;
  logic [DataWidth-1:0] head_data;
  logic                 unused_meta;

  // Request path: combinational feed-through, held off while reset is asserted.
  // Full is deliberately not relieved by a same-cycle retire.
  assign out_valid_o = rst_ni & req_valid_i & ~full;
  assign req_ready_o = rst_ni & out_ready_i & ~full;
  assign issue       = out_valid_o & out_ready_i;
  assign drop        = DropWriteResp & req_write_i & (req_amo_i == AmoNone);

  assign out_addr_o         = rst_ni ? req_addr_i  : '0;
  assign out_amo_o          = rst_ni ? req_amo_i   : '0;
  assign out_write_o        = rst_ni & req_write_i;
  assign out_wdata_o        = rst_ni ? req_wdata_i : '0;
  assign out_be_o           = rst_ni ? req_be_i    : '0;
  assign out_meta_o.core_id = rst_ni ? core_id_i   : '0;
  assign out_meta_o.tag     = MetaTagWidth'(tail);

  assign in_ready_o  = 1'b1;
  assign unused_meta = ^{in_meta_i.core_id, in_meta_i.tag[MetaTagWidth-1:TagWidth]};

  // Response path: dropped heads retire on their own, others wait for the core.
  assign resp_valid_o = head_valid & ~head_drop;
  assign resp_rdata_o = resp_valid_o ? head_data : '0;
  assign pop          = head_valid & (head_drop | resp_ready_i);

  tcdm_rob #(
    .NumOutstanding(NumOutstanding),
    .DataWidth     (DataWidth),
    .TagWidth      (TagWidth)
  ) i_rob (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alloc_i     (issue),
    .alloc_drop_i(drop),
    .tail_o      (tail),
    .full_o      (full),
    .wr_valid_i  (in_valid_i),
    .wr_tag_i    (in_meta_i.tag[TagWidth-1:0]),
    .wr_data_i   (in_rdata_i),
    .head_valid_o(head_valid),
    .head_drop_o (head_drop),
    .head_data_o (head_data),
    .pop_i       (pop)
  );

endmodule

// File: tb/tb_tcdm_initiator.sv
// Directed bench for tcdm_initiator: transaction-queue model checked every
// cycle plus literal expectations for each scenario.
module tb_tcdm_initiator;
  import tcdm_initiator_pkg::*;

  localparam int N = 8;

  logic                   clk = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [CoreIdWidth-1:0] core_id = 8'h5;
  logic                   req_valid = 1'b0, req_ready_o;
  logic [31:0]            req_addr = '0;
  logic [3:0]             req_amo = '0;
  logic                   req_write = 1'b0;
  logic [31:0]            req_wdata = '0;
  logic [3:0]             req_be = 4'hF;
  logic                   resp_valid_o, resp_ready = 1'b1;
  logic [31:0]            resp_rdata_o;
  logic                   out_valid_o, out_ready = 1'b1;
  logic [31:0]            out_addr_o, out_wdata_o;
  logic [3:0]             out_amo_o, out_be_o;
  logic                   out_write_o;
  tcdm_init_meta_t        out_meta_o;
  logic                   in_valid = 1'b0, in_ready_o;
  logic [31:0]            in_rdata = '0;
  tcdm_init_meta_t        in_meta = '0;

  int n_chk = 0, n_fail = 0;

  tcdm_initiator #(.NumOutstanding(N)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .core_id_i(core_id),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
    .req_amo_i(req_amo), .req_write_i(req_write), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_addr_o(out_addr_o),
    .out_amo_o(out_amo_o), .out_write_o(out_write_o), .out_wdata_o(out_wdata_o),
    .out_be_o(out_be_o), .out_meta_o(out_meta_o),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_rdata_i(in_rdata), .in_meta_i(in_meta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Model: in-flight transactions as an ordered queue ----------------
  typedef struct {
    int          tag;
    bit          drop;
    bit          done;
    logic [31:0] data;
  } txn_t;

  txn_t        m_q[$];
  int          m_issued = 0;
  logic [31:0] delivered[$];

  always @(posedge clk) begin
    if (!rst_ni) begin
      m_q.delete();
      m_issued = 0;
    end else begin
      bit do_issue;
      do_issue = req_valid && out_ready && (m_q.size() < N);
      if (m_q.size() > 0 && m_q[0].done && (m_q[0].drop || resp_ready)) begin
        if (!m_q[0].drop) delivered.push_back(m_q[0].data);
        void'(m_q.pop_front());
      end
      if (in_valid) begin
        foreach (m_q[i]) if (m_q[i].tag == int'(in_meta.tag)) begin
          m_q[i].done = 1'b1;
          m_q[i].data = in_rdata;
        end
      end
      if (do_issue) begin
        txn_t t;
        t.tag  = m_issued % N;
        t.drop = req_write && (req_amo == 4'h0);
        t.done = 1'b0;
        t.data = '0;
        m_q.push_back(t);
        m_issued++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      bit exp_rv;
      exp_rv = (m_q.size() > 0) && m_q[0].done && !m_q[0].drop;
      chk("m_req_ready", 32'(req_ready_o), 32'(out_ready && (m_q.size() < N)));
      chk("m_out_valid", 32'(out_valid_o), 32'(req_valid && (m_q.size() < N)));
      chk("m_tag", 32'(out_meta_o.tag), 32'(m_issued % N));
      chk("m_core_id", 32'(out_meta_o.core_id), 32'(core_id));
      chk("m_in_ready", 32'(in_ready_o), 32'd1);
      chk("m_resp_valid", 32'(resp_valid_o), 32'(exp_rv));
      if (exp_rv) chk("m_resp_rdata", resp_rdata_o, m_q[0].data);
      if (out_valid_o) chk("m_fwd_addr", out_addr_o, req_addr);
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = 1'b1; out_ready = 1'b1; resp_ready = 1'b1; in_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    repeat (2) tick();
    req_valid = 1'b0;
    delivered.delete();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [31:0] addr, input logic wr, input logic [3:0] amo,
                       input int exp_tag);
    int n = 0;
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_amo = amo; req_wdata = addr ^ 32'hA5A5;
    #1;
    while (!req_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready_o) chk("issue_timeout", 32'd0, 32'd1);
    else chk("issue_tag", 32'(out_meta_o.tag), 32'(exp_tag));
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_amo = 4'h0;
  endtask

  task automatic respond(input int tag, input logic [31:0] d);
    in_valid = 1'b1; in_meta.core_id = core_id; in_meta.tag = 8'(tag); in_rdata = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    apply_reset();

    // In order
    issue(32'h100, 1'b0, 4'h0, 0);
    issue(32'h104, 1'b0, 4'h0, 1);
    chk("ino_idle", 32'(resp_valid_o), 32'd0);
    respond(0, 32'h11);
    chk("ino_v0", 32'(resp_valid_o), 32'd1);
    chk("ino_d0", resp_rdata_o, 32'h11);
    respond(1, 32'h22);
    chk("ino_d1", resp_rdata_o, 32'h22);
    tick();
    chk("ino_n", 32'(delivered.size()), 32'd2);
    chk("ino_q0", delivered[0], 32'h11);
    chk("ino_q1", delivered[1], 32'h22);

    // Out of order
    apply_reset();
    for (int i = 0; i < 3; i++) issue(32'h200 + 32'(4 * i), 1'b0, 4'h0, i);
    respond(2, 32'hC);
    chk("ooo_hold", 32'(resp_valid_o), 32'd0);
    respond(0, 32'hA);
    chk("ooo_a", resp_rdata_o, 32'hA);
    respond(1, 32'hB);
    chk("ooo_b", resp_rdata_o, 32'hB);
    tick();
    chk("ooo_c", resp_rdata_o, 32'hC);
    tick();
    chk("ooo_empty", 32'(resp_valid_o), 32'd0);

    // Full, then wrap
    apply_reset();
    for (int i = 0; i < N; i++) issue(32'h300 + 32'(4 * i), 1'b0, 4'h0, i);
    req_valid = 1'b1; req_addr = 32'h400;
    #1;
    chk("full_ready", 32'(req_ready_o), 32'd0);
    chk("full_valid", 32'(out_valid_o), 32'd0);
    respond(0, 32'h5A);
    chk("full_nobypass", 32'(req_ready_o), 32'd0);
    chk("full_resp", resp_rdata_o, 32'h5A);
    tick();
    chk("full_freed", 32'(req_ready_o), 32'd1);
    chk("full_wrap_tag", 32'(out_meta_o.tag), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("full_again", 32'(req_ready_o), 32'd0);
    chk("full_tail", 32'(out_meta_o.tag), 32'd1);

    // Dropped store, and an SC store that is not dropped
    apply_reset();
    issue(32'h500, 1'b1, 4'h0, 0);
    issue(32'h504, 1'b0, 4'h0, 1);
    respond(0, 32'hDEAD);
    chk("drop_silent", 32'(resp_valid_o), 32'd0);
    respond(1, 32'h77);
    chk("drop_load", resp_rdata_o, 32'h77);
    tick();
    chk("drop_empty", 32'(m_q.size()), 32'd0);
    issue(32'h508, 1'b1, 4'hB, 2);
    respond(2, 32'h1);
    chk("sc_valid", 32'(resp_valid_o), 32'd1);
    chk("sc_data", resp_rdata_o, 32'h1);
    tick();
    chk("drop_n", 32'(delivered.size()), 32'd2);
    chk("drop_q0", delivered[0], 32'h77);

    // Backpressure
    apply_reset();
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(32'h600 + 32'(4 * i), 1'b0, 4'h0, i);
    respond(1, 32'h32);
    respond(2, 32'h33);
    respond(0, 32'h31);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(resp_valid_o), 32'd1);
      chk("bp_stable", resp_rdata_o, 32'h31);
      chk("bp_in_ready", 32'(in_ready_o), 32'd1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_r0", resp_rdata_o, 32'h31);
    tick();
    chk("bp_r1", resp_rdata_o, 32'h32);
    tick();
    chk("bp_r2", resp_rdata_o, 32'h33);
    tick();
    chk("bp_done", 32'(resp_valid_o), 32'd0);

    // Reset mid-flight
    for (int i = 0; i < 4; i++) issue(32'h700 + 32'(4 * i), 1'b0, 4'h0, 3 + i);
    respond(3, 32'h99);
    apply_reset();
    chk("mid_resp_valid", 32'(resp_valid_o), 32'd0);
    issue(32'h800, 1'b0, 4'h0, 0);
    respond(0, 32'h42);
    chk("mid_fresh", resp_rdata_o, 32'h42);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
